// File: rtl/sad_tree_pipe.sv
// Pipelined sum-of-absolute-differences engine: per-pixel |a-b|, registered adder tree,
// per-block saturating accumulator and running minimum (best-match) tracker.
module sad_tree_pipe #(
  parameter int NUM_PIX = 16,
  parameter int PIX_W   = 8,
  parameter int ROW_W   = 4,
  parameter int IDX_W   = 8,
  localparam int LVL    = $clog2(NUM_PIX),
  localparam int SUM_W  = PIX_W + LVL + ROW_W
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_PIX*PIX_W-1:0] in_a,
  input  logic [NUM_PIX*PIX_W-1:0] in_b,
  input  logic                     in_last,
  input  logic                     clear_min,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SUM_W-1:0]         out_sad,
  output logic                     out_sat,
  output logic [IDX_W-1:0]         out_idx,
  output logic [SUM_W-1:0]         best_sad,
  output logic [IDX_W-1:0]         best_idx
);

  localparam int TREE_W = PIX_W + LVL;
  localparam logic [SUM_W-1:0] SUM_MAX = {SUM_W{1'b1}};

  logic              en;
  logic [LVL:0]      vld_d, vld_q, lst_d, lst_q;
  logic [TREE_W-1:0] tree_sum;

  logic [SUM_W-1:0]  acc_d, acc_q, out_sad_d, out_sad_q, best_sad_d, best_sad_q;
  logic              sat_d, sat_q, first_d, first_q;
  logic              out_sat_d, out_sat_q, out_valid_d, out_valid_q;
  logic [IDX_W-1:0]  blk_idx_d, blk_idx_q, out_idx_d, out_idx_q, best_idx_d, best_idx_q;
  logic [SUM_W:0]    sum_ext;
  logic [SUM_W-1:0]  sum_clamp;
  logic              sum_ovf, sat_new, load;

  // The whole pipeline freezes while a result is waiting to be consumed.
  assign en       = ~out_valid_q | out_ready;
  assign in_ready = en;

  // Valid and last markers travel alongside the data through every tree stage.
  always_comb begin
    if (en) begin
      vld_d = {vld_q[LVL-1:0], in_valid};
      lst_d = {lst_q[LVL-1:0], in_last};
    end else begin
      vld_d = vld_q;
      lst_d = lst_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      vld_q <= {(LVL+1){1'b0}};
      lst_q <= {(LVL+1){1'b0}};
    end else begin
      vld_q <= vld_d;
      lst_q <= lst_d;
    end
  end

  // Level 0 holds per-pixel differences; level j holds NUM_PIX>>j partial sums of PIX_W+j bits.
  for (genvar j = 0; j <= LVL; j++) begin : g_lvl
    localparam int N = NUM_PIX >> j;
    localparam int W = PIX_W + j;
    logic [W-1:0] s_d [N];
    logic [W-1:0] s_q [N];

    if (j == 0) begin : g_abs
      always_comb begin
        for (int k = 0; k < N; k++) begin
          if (!en) begin
            s_d[k] = s_q[k];
          end else if (in_a[k*PIX_W +: PIX_W] >= in_b[k*PIX_W +: PIX_W]) begin
            s_d[k] = in_a[k*PIX_W +: PIX_W] - in_b[k*PIX_W +: PIX_W];
          end else begin
            s_d[k] = in_b[k*PIX_W +: PIX_W] - in_a[k*PIX_W +: PIX_W];
          end
        end
      end
    end else begin : g_add
      always_comb begin
        for (int k = 0; k < N; k++) begin
          if (en) begin
            s_d[k] = {1'b0, g_lvl[j-1].s_q[2*k]} + {1'b0, g_lvl[j-1].s_q[2*k+1]};
          end else begin
            s_d[k] = s_q[k];
          end
        end
      end
    end

    always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
        for (int k = 0; k < N; k++) s_q[k] <= {W{1'b0}};
      end else begin
        s_q <= s_d;
      end
    end
  end

  assign tree_sum = g_lvl[LVL].s_q[0];

  // Accumulate, emit block results and track the smallest result since clear_min.
  always_comb begin
    sum_ext = {(SUM_W+1){1'b0}};
    sum_ext[TREE_W-1:0] = tree_sum;
    if (first_q) begin
      sum_ext = sum_ext;
    end else begin
      sum_ext = sum_ext + {1'b0, acc_q};
    end
    sum_ovf   = sum_ext[SUM_W];
    sum_clamp = sum_ovf ? SUM_MAX : sum_ext[SUM_W-1:0];
    sat_new   = sum_ovf | (~first_q & sat_q);
    load      = en & vld_q[LVL];

    acc_d       = acc_q;
    sat_d       = sat_q;
    first_d     = first_q;
    out_sad_d   = out_sad_q;
    out_sat_d   = out_sat_q;
    out_idx_d   = out_idx_q;
    out_valid_d = out_valid_q & ~out_ready;
    blk_idx_d   = blk_idx_q;
    best_sad_d  = best_sad_q;
    best_idx_d  = best_idx_q;

    if (load && lst_q[LVL]) begin
      acc_d       = {SUM_W{1'b0}};
      sat_d       = 1'b0;
      first_d     = 1'b1;
      out_sad_d   = sum_clamp;
      out_sat_d   = sat_new;
      out_idx_d   = blk_idx_q;
      out_valid_d = 1'b1;
      blk_idx_d   = blk_idx_q + IDX_W'(1);
      if (sum_clamp < best_sad_q) begin
        best_sad_d = sum_clamp;
        best_idx_d = blk_idx_q;
      end else begin
        best_sad_d = best_sad_q;
        best_idx_d = best_idx_q;
      end
    end else if (load) begin
      acc_d   = sum_clamp;
      sat_d   = sat_new;
      first_d = 1'b0;
    end else begin
      acc_d = acc_q;
    end

    // A clear in the same cycle as a load wins for the tracker; the loaded result keeps its index.
    if (clear_min) begin
      best_sad_d = SUM_MAX;
      best_idx_d = {IDX_W{1'b0}};
      blk_idx_d  = {IDX_W{1'b0}};
    end else begin
      blk_idx_d = blk_idx_d;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      acc_q       <= {SUM_W{1'b0}};
      sat_q       <= 1'b0;
      first_q     <= 1'b1;
      out_sad_q   <= {SUM_W{1'b0}};
      out_sat_q   <= 1'b0;
      out_idx_q   <= {IDX_W{1'b0}};
      out_valid_q <= 1'b0;
      blk_idx_q   <= {IDX_W{1'b0}};
      best_sad_q  <= SUM_MAX;
      best_idx_q  <= {IDX_W{1'b0}};
    end else begin
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      first_q     <= first_d;
      out_sad_q   <= out_sad_d;
      out_sat_q   <= out_sat_d;
      out_idx_q   <= out_idx_d;
      out_valid_q <= out_valid_d;
      blk_idx_q   <= blk_idx_d;
      best_sad_q  <= best_sad_d;
      best_idx_q  <= best_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sad   = out_sad_q;
  assign out_sat   = out_sat_q;
  assign out_idx   = out_idx_q;
  assign best_sad  = best_sad_q;
  assign best_idx  = best_idx_q;

endmodule

// File: tb/tb_sad_tree_pipe.sv
// Self-checking bench for sad_tree_pipe: directed table, latency/stall/reset sequences and
// randomized traffic against a block-level scoreboard model.
module tb_sad_tree_pipe;
  localparam int NP = 16, PW = 8, RW = 4, IW = 8, LV = 4;
  localparam int SW = PW + LV + RW;
  localparam int SW2 = PW + LV;
  localparam int DW = NP * PW;
  localparam int SAD_MAX = (1 << SW) - 1;

  logic Clk = 1'b0, Reset = 1'b0;
  logic in_valid = 1'b0, in_last = 1'b0, clear_min = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] in_a = '0, in_b = '0;
  logic in_ready, out_valid, out_sat;
  logic [SW-1:0] out_sad, best_sad;
  logic [IW-1:0] out_idx, best_idx;
  logic in_ready2, out_valid2, out_sat2;
  logic [SW2-1:0] out_sad2, best_sad2;
  logic [IW-1:0] out_idx2, best_idx2;

  always #5 Clk = ~Clk;

  sad_tree_pipe #(.NUM_PIX(NP), .PIX_W(PW), .ROW_W(RW), .IDX_W(IW)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .clear_min(clear_min), .out_valid(out_valid), .out_ready(out_ready),
    .out_sad(out_sad), .out_sat(out_sat), .out_idx(out_idx), .best_sad(best_sad), .best_idx(best_idx));

  // Narrow-accumulator instance sharing the input stream, used for the saturation corner.
  sad_tree_pipe #(.NUM_PIX(NP), .PIX_W(PW), .ROW_W(0), .IDX_W(IW)) dut2 (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready2), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .clear_min(clear_min), .out_valid(out_valid2), .out_ready(1'b1),
    .out_sad(out_sad2), .out_sat(out_sat2), .out_idx(out_idx2), .best_sad(best_sad2), .best_idx(best_idx2));

  int n_assert = 0, n_fail = 0;
  int m_acc = 0, m_idx = 0, m_best = SAD_MAX, m_bidx = 0, n_popped = 0;
  bit rnd_on = 1'b0;

  typedef struct { int sad; bit sat; int idx; } res_t;
  res_t exp_q[$];

  typedef struct { int a; int b; int npix; int nb; int sad; bit sat; int sad2; bit sat2; } vec_t;
  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int beat_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s, x, y;
    s = 0;
    for (int k = 0; k < NP; k++) begin
      x = int'(a[k*PW +: PW]);
      y = int'(b[k*PW +: PW]);
      s += (x > y) ? x - y : y - x;
    end
    return s;
  endfunction

  function automatic logic [DW-1:0] fill(input int v, input int npix);
    logic [DW-1:0] x;
    x = '0;
    for (int k = 0; k < npix; k++) x[k*PW +: PW] = PW'(v);
    return x;
  endfunction

  function automatic logic [DW-1:0] rnd_vec();
    logic [DW-1:0] v;
    for (int w = 0; w < DW/32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  // Model: every accepted beat adds its SAD; a last beat closes the block into the expected queue.
  always @(negedge Clk) begin
    res_t r;
    if (Reset && in_valid && in_ready) begin
      m_acc += beat_sum(in_a, in_b);
      if (in_last) begin
        r.sad = (m_acc > SAD_MAX) ? SAD_MAX : m_acc;
        r.sat = (m_acc > SAD_MAX);
        r.idx = m_idx;
        exp_q.push_back(r);
        m_idx = (m_idx + 1) % (1 << IW);
        m_acc = 0;
      end
    end
  end

  // Scoreboard: each consumed result must be the oldest expected block; best tracks the minimum.
  always @(negedge Clk) begin
    res_t r;
    if (Reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        r = exp_q.pop_front();
        n_popped++;
        check("sb_out_sad", out_sad, r.sad);
        check("sb_out_sat", out_sat, r.sat);
        check("sb_out_idx", out_idx, r.idx);
        if (r.sad < m_best) begin
          m_best = r.sad;
          m_bidx = r.idx;
        end
        check("sb_best_sad", best_sad, m_best);
        check("sb_best_idx", best_idx, m_bidx);
      end
    end
  end

  task automatic do_reset();
    Reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; clear_min = 1'b0;
    exp_q.delete(); m_acc = 0; m_idx = 0; m_best = SAD_MAX; m_bidx = 0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
  endtask

  task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
    int w;
    bit ok;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    ok = 1'b0; w = 0;
    while (!ok && w < 500) begin
      @(negedge Clk); ok = in_ready;
      @(posedge Clk); #1;
      w++;
    end
    if (!ok) check("beat_accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_block(input int a, input int b, input int npix, input int nb);
    for (int i = 0; i < nb; i++) send_beat(fill(a, npix), fill(b, npix), i == nb - 1);
  endtask

  task automatic wait_out();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge Clk);
      ok = out_valid;
    end
    if (!ok) check("result_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (i < 5000) begin
      @(negedge Clk);
      if (exp_q.size() == 0 && !out_valid) break;
      i++;
    end
    @(posedge Clk); #1;
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic pulse_clear();
    clear_min = 1'b1; m_idx = 0; m_best = SAD_MAX; m_bidx = 0;
    @(posedge Clk); #1;
    clear_min = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, pops0;
    bit got;
    tbl[0] = '{10, 3, 16, 1, 112, 0, 112, 0};
    tbl[1] = '{0, 255, 16, 16, 65280, 0, 4095, 1};
    tbl[2] = '{0, 255, 16, 17, 65535, 1, 4095, 1};
    tbl[3] = '{255, 0, 16, 1, 4080, 0, 4080, 0};
    tbl[4] = '{5, 5, 16, 4, 0, 0, 0, 0};
    tbl[5] = '{100, 200, 16, 2, 3200, 0, 3200, 0};
    tbl[6] = '{200, 50, 3, 5, 2250, 0, 2250, 0};

    do_reset();
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_out_sad", out_sad, 32'd0);
    check("rst_out_sat", out_sat, 32'd0);
    check("rst_out_idx", out_idx, 32'd0);
    check("rst_best_sad", best_sad, 32'd65535);
    check("rst_best_idx", best_idx, 32'd0);
    check("rst2_best_sad", best_sad2, 32'd4095);
    check("rst2_best_idx", best_idx2, 32'd0);
    check("rst2_out_idx", out_idx2, 32'd0);
    check("rst2_in_ready", in_ready2, 32'd1);

    // Single-beat block latency: out_valid must rise on the 6th edge after presentation.
    in_valid = 1'b1; in_a = fill(10, NP); in_b = fill(3, NP); in_last = 1'b1;
    lat = 0; got = 1'b0;
    while (lat < 20 && !got) begin
      @(posedge Clk); lat++;
      #1 in_valid = 1'b0; in_last = 1'b0;
      @(negedge Clk); got = out_valid;
    end
    check("latency", lat, 32'd6);
    check("t1_out_sad", out_sad, 32'd112);
    check("t1_out_sat", out_sat, 32'd0);
    check("t1_out_idx", out_idx, 32'd0);
    @(posedge Clk); #1;

    for (int t = 0; t < 7; t++) begin
      send_block(tbl[t].a, tbl[t].b, tbl[t].npix, tbl[t].nb);
      wait_out();
      check("tbl_out_sad", out_sad, tbl[t].sad);
      check("tbl_out_sat", out_sat, tbl[t].sat);
      check("tbl_out_idx", out_idx, t + 1);
      check("tbl_valid2", out_valid2, 32'd1);
      check("tbl_out_sad2", out_sad2, tbl[t].sad2);
      check("tbl_out_sat2", out_sat2, tbl[t].sat2);
      @(posedge Clk); #1;
    end
    drain();

    // Best-match: 500,300,300,700 -> 300 at index 1 (tie keeps the earlier block).
    pulse_clear();
    send_block(250, 0, 1, 2);
    send_block(150, 0, 2, 1);
    send_block(150, 0, 2, 1);
    send_block(175, 0, 4, 1);
    drain();
    check("best_sad_300", best_sad, 32'd300);
    check("best_idx_1", best_idx, 32'd1);
    pulse_clear();
    check("clr_best_sad", best_sad, 32'd65535);
    check("clr_best_idx", best_idx, 32'd0);
    send_block(1, 0, 1, 1);
    wait_out();
    check("clr_next_idx", out_idx, 32'd0);
    check("clr_next_sad", out_sad, 32'd1);
    drain();

    // Back-pressure: three blocks queue up behind a stalled output and emerge in order.
    out_ready = 1'b0;
    pops0 = n_popped;
    fork
      begin
        send_block(9, 1, 16, 1);
        send_block(1, 9, 8, 1);
        send_block(20, 0, 1, 3);
      end
      begin
        repeat (30) @(posedge Clk);
        @(negedge Clk);
        check("stall_in_ready", in_ready, 32'd0);
        check("stall_out_valid", out_valid, 32'd1);
        check("stall_out_sad", out_sad, 32'd128);
        check("stall_pending", exp_q.size(), 32'd3);
        @(posedge Clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    check("stall_results", n_popped - pops0, 32'd3);

    // Randomized traffic with input gaps and 50% output back-pressure.
    pops0 = n_popped;
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          @(posedge Clk); #1 out_ready = ($urandom_range(0, 1) == 1);
        end
      end
      begin
        for (int n = 0; n < 1000; n++) begin
          int nb;
          nb = $urandom_range(1, 4);
          for (int i = 0; i < nb; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
            send_beat(rnd_vec(), rnd_vec(), i == nb - 1);
          end
        end
        rnd_on = 1'b0;
      end
    join
    out_ready = 1'b1;
    drain();
    check("rnd_results", n_popped - pops0, 32'd1000);

    // Reset mid-block: held result vanishes at once, next block starts fresh at index 0.
    out_ready = 1'b0;
    send_block(10, 3, 16, 1);
    for (int i = 0; i < 5; i++) send_beat(fill(7, NP), fill(0, NP), 1'b0);
    wait_out();
    #2 Reset = 1'b0;
    #1;
    check("rst_mid_out_valid", out_valid, 32'd0);
    check("rst_mid_in_ready", in_ready, 32'd1);
    do_reset();
    out_ready = 1'b1;
    send_block(4, 0, 16, 8);
    wait_out();
    check("post_rst_sad", out_sad, 32'd512);
    check("post_rst_idx", out_idx, 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
